// File: rtl/wishbone_classic_fifo_device.sv
// Wishbone B4 classic device that terminates single read/write cycles in a
// small synchronous FIFO. Writes push, reads pop. Every accepted request gets
// exactly one registered response cycle (ack, or rty/err on full/empty).
module wishbone_classic_fifo_device #(
    parameter int unsigned DAT_WIDTH     = 8,
    parameter int unsigned DEPTH         = 4,
    parameter bit          RETRY_NOT_ERR = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cyc_i,
    input  logic                       stb_i,
    input  logic                       we_i,
    input  logic [DAT_WIDTH-1:0]       dat_i,
    output logic                       ack_o,
    output logic                       err_o,
    output logic                       rty_o,
    output logic [DAT_WIDTH-1:0]       dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic StIdle = 1'b0;
    localparam logic StResp = 1'b1;

    logic                 state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 rty_q, rty_d;
    logic                 fail;
    logic                 push;
    logic                 req;
    logic                 full;
    logic                 empty;

    logic [DAT_WIDTH-1:0] mem_q [DEPTH];

    assign req   = cyc_i & stb_i;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state: a request is only sampled in IDLE; RESP always lasts one cycle.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dat_d    = dat_q;
        ack_d    = 1'b0;
        fail     = 1'b0;
        push     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StResp;
                    if (we_i) begin
                        if (!full) begin
                            push     = 1'b1;
                            wr_ptr_d = wr_ptr_q + AW'(1);
                            count_d  = count_q + CW'(1);
                            ack_d    = 1'b1;
                        end else begin
                            fail = 1'b1;
                        end
                    end else begin
                        if (!empty) begin
                            dat_d    = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + AW'(1);
                            count_d  = count_q - CW'(1);
                            ack_d    = 1'b1;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        rty_d = fail & RETRY_NOT_ERR;
        err_d = fail & ~RETRY_NOT_ERR;
    end

    // Control state, pointers, occupancy, read data and the response flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rty_q    <= rty_d;
        end
    end

    // Storage has no reset; contents are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rty_o   = rty_q;
    assign dat_o   = dat_q;
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: tb/tb_wishbone_classic_fifo_device.sv
// Directed bench for wishbone_classic_fifo_device. Two instances share the
// stimulus: one terminating failures with rty_o, the other with err_o.
module tb_wishbone_classic_fifo_device;

    logic       clk;
    logic       rst_ni;
    logic       cyc, stb, we;
    logic [7:0] dat_in;

    logic       ack_r, err_r, rty_r, full_r, empty_r;
    logic [7:0] dat_r;
    logic [2:0] cnt_r;
    logic       ack_e, err_e, rty_e, full_e, empty_e;
    logic [7:0] dat_e;
    logic [2:0] cnt_e;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       cyc;
        logic       stb;
        logic       we;
        logic [7:0] dat;
        logic       e_ack;
        logic       e_fail;
        logic [7:0] e_dat;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    wishbone_classic_fifo_device #(
        .DAT_WIDTH    (8),
        .DEPTH        (4),
        .RETRY_NOT_ERR(1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .we_i   (we),
        .dat_i  (dat_in),
        .ack_o  (ack_r),
        .err_o  (err_r),
        .rty_o  (rty_r),
        .dat_o  (dat_r),
        .count_o(cnt_r),
        .full_o (full_r),
        .empty_o(empty_r)
    );

    wishbone_classic_fifo_device #(
        .DAT_WIDTH    (8),
        .DEPTH        (4),
        .RETRY_NOT_ERR(1'b0)
    ) dut_e (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .cyc_i  (cyc),
        .stb_i  (stb),
        .we_i   (we),
        .dat_i  (dat_in),
        .ack_o  (ack_e),
        .err_o  (err_e),
        .rty_o  (rty_e),
        .dat_o  (dat_e),
        .count_o(cnt_e),
        .full_o (full_e),
        .empty_o(empty_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_both(input string tag, input logic e_ack, input logic e_fail,
                            input logic [7:0] e_dat, input logic [2:0] e_cnt);
        chk({tag, " rty.ack"},   {31'd0, ack_r},   {31'd0, e_ack});
        chk({tag, " rty.rty"},   {31'd0, rty_r},   {31'd0, e_fail});
        chk({tag, " rty.err"},   {31'd0, err_r},   32'd0);
        chk({tag, " rty.dat"},   {24'd0, dat_r},   {24'd0, e_dat});
        chk({tag, " rty.count"}, {29'd0, cnt_r},   {29'd0, e_cnt});
        chk({tag, " rty.full"},  {31'd0, full_r},  {31'd0, (e_cnt == 3'd4)});
        chk({tag, " rty.empty"}, {31'd0, empty_r}, {31'd0, (e_cnt == 3'd0)});
        chk({tag, " err.ack"},   {31'd0, ack_e},   {31'd0, e_ack});
        chk({tag, " err.err"},   {31'd0, err_e},   {31'd0, e_fail});
        chk({tag, " err.rty"},   {31'd0, rty_e},   32'd0);
        chk({tag, " err.dat"},   {24'd0, dat_e},   {24'd0, e_dat});
        chk({tag, " err.count"}, {29'd0, cnt_e},   {29'd0, e_cnt});
    endtask

    function automatic void add(input logic c, input logic s, input logic w, input logic [7:0] d,
                                input logic ea, input logic ef, input logic [7:0] ed,
                                input logic [2:0] ec);
        vec_t v;
        v.cyc    = c;
        v.stb    = s;
        v.we     = w;
        v.dat    = d;
        v.e_ack  = ea;
        v.e_fail = ef;
        v.e_dat  = ed;
        v.e_cnt  = ec;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] prev;

        // Idle after reset release.
        for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd0);
        // cyc without stb is not a request.
        add(1, 0, 1, 8'hFF, 0, 0, 8'h00, 3'd0);
        add(1, 0, 0, 8'hFF, 0, 0, 8'h00, 3'd0);
        // Single write, then request held through the ack: second push one cycle later.
        add(1, 1, 1, 8'hA5, 1, 0, 8'h00, 3'd1);
        add(1, 1, 1, 8'hA5, 0, 0, 8'h00, 3'd1);
        add(1, 1, 1, 8'hA5, 1, 0, 8'h00, 3'd2);
        add(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd2);
        // Drain them.
        add(1, 1, 0, 8'h00, 1, 0, 8'hA5, 3'd1);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd1);
        add(1, 1, 0, 8'h00, 1, 0, 8'hA5, 3'd0);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd0);
        // Fill to DEPTH, fifth write is refused.
        add(1, 1, 1, 8'h01, 1, 0, 8'hA5, 3'd1);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd1);
        add(1, 1, 1, 8'h02, 1, 0, 8'hA5, 3'd2);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd2);
        add(1, 1, 1, 8'h03, 1, 0, 8'hA5, 3'd3);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd3);
        add(1, 1, 1, 8'h04, 1, 0, 8'hA5, 3'd4);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd4);
        add(1, 1, 1, 8'h05, 0, 1, 8'hA5, 3'd4);
        add(0, 0, 0, 8'h00, 0, 0, 8'hA5, 3'd4);
        // Empty it, fifth read is refused and dat_o holds 04.
        add(1, 1, 0, 8'h00, 1, 0, 8'h01, 3'd3);
        add(0, 0, 0, 8'h00, 0, 0, 8'h01, 3'd3);
        add(1, 1, 0, 8'h00, 1, 0, 8'h02, 3'd2);
        add(0, 0, 0, 8'h00, 0, 0, 8'h02, 3'd2);
        add(1, 1, 0, 8'h00, 1, 0, 8'h03, 3'd1);
        add(0, 0, 0, 8'h00, 0, 0, 8'h03, 3'd1);
        add(1, 1, 0, 8'h00, 1, 0, 8'h04, 3'd0);
        add(0, 0, 0, 8'h00, 0, 0, 8'h04, 3'd0);
        add(1, 1, 0, 8'h00, 0, 1, 8'h04, 3'd0);
        add(0, 0, 0, 8'h00, 0, 0, 8'h04, 3'd0);
        // Interleaved pairs across pointer wrap-around.
        for (int i = 0; i < 10; i++) begin
            prev = (i == 0) ? 8'h04 : 8'(8'h10 + i - 1);
            add(1, 1, 1, 8'(8'h10 + i), 1, 0, prev, 3'd1);
            add(0, 0, 0, 8'h00, 0, 0, prev, 3'd1);
            add(1, 1, 0, 8'h00, 1, 0, 8'(8'h10 + i), 3'd0);
            add(0, 0, 0, 8'h00, 0, 0, 8'(8'h10 + i), 3'd0);
        end

        // Reset state, checked while reset is held.
        rst_ni = 1'b0;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        dat_in = 8'h00;
        #3;
        chk_both("reset", 0, 0, 8'h00, 3'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        foreach (vecs[k]) begin
            cyc    = vecs[k].cyc;
            stb    = vecs[k].stb;
            we     = vecs[k].we;
            dat_in = vecs[k].dat;
            @(posedge clk);
            #1;
            chk_both($sformatf("vec%0d", k), vecs[k].e_ack, vecs[k].e_fail,
                     vecs[k].e_dat, vecs[k].e_cnt);
        end

        // Response survives cyc dropping in RESP; async reset then kills it.
        cyc    = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        dat_in = 8'h77;
        @(posedge clk);
        #1;
        chk_both("abort.resp", 1, 0, 8'h19, 3'd1);
        cyc = 1'b0;
        stb = 1'b0;
        #2;
        chk_both("abort.cycdrop", 1, 0, 8'h19, 3'd1);
        rst_ni = 1'b0;
        #1;
        chk_both("abort.rst", 0, 0, 8'h00, 3'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_both($sformatf("post_rst%0d", i), 0, 0, 8'h00, 3'd0);
        end
        // The 0x77 push was wiped by reset, so a read is refused.
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b0;
        @(posedge clk);
        #1;
        chk_both("post_rst.read", 0, 1, 8'h00, 3'd0);
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        #1;
        chk_both("post_rst.idle", 0, 0, 8'h00, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
